// File: rtl/sa_a_skew_feeder.sv
// West-edge A feeder for the INT8 systolic array: accepts one SIZE-lane int8 vector
// per beat and skews lane i by i extra cycles, then drains with zeros at tile end.
module sa_a_skew_feeder #(
    parameter int SIZE  = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk_i,
    input  logic                reset,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [SIZE*8-1:0]   in_data_i,
    input  logic                in_last_i,
    output logic [SIZE*8-1:0]   lane_data_o,
    output logic [SIZE-1:0]     lane_valid_o,
    output logic                busy_o,
    output logic                tile_done_o,
    output logic [CNT_W-1:0]    tile_len_o
);

    // Flush counter loads SIZE-2 and counts down to zero, giving SIZE-1 flush cycles.
    localparam int FW = (SIZE > 2) ? $clog2(SIZE) : 1;
    localparam logic [FW-1:0] FLUSH_INIT = FW'((SIZE > 1) ? SIZE - 2 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [FW-1:0]    flush_q, flush_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] len_q, len_d;
    logic             done_q, done_d;
    logic             accept;

    assign in_ready_o  = (state_q != FLUSH) && !reset;
    assign accept      = in_valid_i && in_ready_o;
    assign busy_o      = (state_q != IDLE);
    assign tile_done_o = done_q;
    assign tile_len_o  = len_q;

    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        done_d  = 1'b0;
        cnt_inc = (accept && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
        case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    if (in_last_i) begin
                        if (SIZE == 1) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = FLUSH;
                            flush_d = FLUSH_INIT;
                        end
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            FLUSH: begin
                if (flush_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    flush_d = flush_q - FW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // The done edge captures the count including a same-edge last beat (SIZE==1).
        cnt_d = done_d ? '0 : cnt_inc;
        len_d = done_d ? cnt_inc : len_q;
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            flush_q <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        localparam int W = i + 1;
        logic [8*W-1:0] data_q, data_d;
        logic [W-1:0]   vld_q, vld_d;
        logic [7:0]     stage0;

        assign stage0 = accept ? in_data_i[8*i +: 8] : 8'd0;

        always_comb begin
            data_d = (data_q << 8) | (8*W)'(stage0);
            vld_d  = (vld_q << 1) | W'(accept);
        end

        always_ff @(posedge clk_i or posedge reset) begin
            if (reset) begin
                data_q <= '0;
                vld_q  <= '0;
            end else begin
                data_q <= data_d;
                vld_q  <= vld_d;
            end
        end

        assign lane_data_o[8*i +: 8] = data_q[8*i +: 8];
        assign lane_valid_o[i]       = vld_q[i];
    end

endmodule

// File: tb/tb_sa_a_skew_feeder.sv
// Directed bench for sa_a_skew_feeder: a SIZE=4 instance for skew, flush, bubbles,
// back-to-back tiles and async reset, plus a SIZE=1 instance for the degenerate case.
module tb_sa_a_skew_feeder;

    logic        clk_i = 1'b0;
    logic        reset = 1'b1;

    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_data_i  = '0;
    logic        in_last_i  = 1'b0;
    logic [31:0] lane_data_o;
    logic [3:0]  lane_valid_o;
    logic        busy_o;
    logic        tile_done_o;
    logic [15:0] tile_len_o;

    logic        v1 = 1'b0;
    logic        rdy1;
    logic [7:0]  d1 = '0;
    logic        l1 = 1'b0;
    logic [7:0]  ld1;
    logic [0:0]  lv1;
    logic        busy1;
    logic        done1;
    logic [15:0] len1;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    sa_a_skew_feeder #(.SIZE(4), .CNT_W(16)) u_dut (
        .clk_i        (clk_i),
        .reset        (reset),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .in_last_i    (in_last_i),
        .lane_data_o  (lane_data_o),
        .lane_valid_o (lane_valid_o),
        .busy_o       (busy_o),
        .tile_done_o  (tile_done_o),
        .tile_len_o   (tile_len_o)
    );

    sa_a_skew_feeder #(.SIZE(1), .CNT_W(16)) u_dut1 (
        .clk_i        (clk_i),
        .reset        (reset),
        .in_valid_i   (v1),
        .in_ready_o   (rdy1),
        .in_data_i    (d1),
        .in_last_i    (l1),
        .lane_data_o  (ld1),
        .lane_valid_o (lv1),
        .busy_o       (busy1),
        .tile_done_o  (done1),
        .tile_len_o   (len1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = last;
    endtask

    task automatic idle();
        in_valid_i = 1'b0;
        in_data_i  = '0;
        in_last_i  = 1'b0;
    endtask

    // Checks the whole lane bus, valids and done flag after an edge.
    task automatic lanes(input string tag, input logic [31:0] d, input logic [3:0] v,
                         input logic done);
        chk({tag, "_data"}, 64'(lane_data_o), 64'(d));
        chk({tag, "_vld"},  64'(lane_valid_o), 64'(v));
        chk({tag, "_done"}, 64'(tile_done_o), 64'(done));
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_ready", 64'(in_ready_o), 64'd0);
        chk("rst_ready1", 64'(rdy1), 64'd0);
        lanes("rst", 32'h0, 4'h0, 1'b0);
        chk("rst_len", 64'(tile_len_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rel_ready", 64'(in_ready_o), 64'd1);

        // in_last_i without valid is ignored
        in_last_i = 1'b1;
        tick();
        chk("lastnv_busy", 64'(busy_o), 64'd0);
        idle();

        // Three back-to-back beats, last on the third
        beat(32'h04030201, 1'b0);
        tick();
        lanes("t1_e0", 32'h00000001, 4'b0001, 1'b0);
        chk("t1_busy", 64'(busy_o), 64'd1);
        beat(32'h08070605, 1'b0);
        tick();
        lanes("t1_e1", 32'h00000205, 4'b0011, 1'b0);
        beat(32'hF40B0A09, 1'b1);
        tick();
        idle();
        lanes("t1_e2", 32'h00030609, 4'b0111, 1'b0);
        chk("t1_rdy_e2", 64'(in_ready_o), 64'd0);
        tick();
        lanes("t1_e3", 32'h04070A00, 4'b1110, 1'b0);
        chk("t1_rdy_e3", 64'(in_ready_o), 64'd0);
        tick();
        lanes("t1_e4", 32'h080B0000, 4'b1100, 1'b0);
        chk("t1_rdy_e4", 64'(in_ready_o), 64'd0);
        tick();
        lanes("t1_e5", 32'hF4000000, 4'b1000, 1'b1);
        chk("t1_len", 64'(tile_len_o), 64'd3);
        chk("t1_rdy_e5", 64'(in_ready_o), 64'd1);
        tick();
        lanes("t1_e6", 32'h0, 4'b0000, 1'b0);
        chk("t1_len_hold", 64'(tile_len_o), 64'd3);
        chk("t1_idle", 64'(busy_o), 64'd0);

        // Bubble mid-tile
        beat(32'h01010101, 1'b0);
        tick();
        idle();
        lanes("t2_f0", 32'h00000001, 4'b0001, 1'b0);
        tick();
        lanes("t2_f1", 32'h00000100, 4'b0010, 1'b0);
        chk("t2_busy_bubble", 64'(busy_o), 64'd1);
        beat(32'h02020202, 1'b1);
        tick();
        idle();
        lanes("t2_f2", 32'h00010002, 4'b0101, 1'b0);
        tick();
        lanes("t2_f3", 32'h01000200, 4'b1010, 1'b0);
        tick();
        lanes("t2_f4", 32'h00020000, 4'b0100, 1'b0);
        tick();
        lanes("t2_f5", 32'h02000000, 4'b1000, 1'b1);
        chk("t2_len", 64'(tile_len_o), 64'd2);

        // Single-beat tile from IDLE
        tick();
        beat(32'h40302010, 1'b1);
        tick();
        idle();
        lanes("t3_g0", 32'h00000010, 4'b0001, 1'b0);
        chk("t3_rdy_g0", 64'(in_ready_o), 64'd0);
        tick();
        chk("t3_rdy_g1", 64'(in_ready_o), 64'd0);
        tick();
        lanes("t3_g2", 32'h00300000, 4'b0100, 1'b0);
        tick();
        lanes("t3_g3", 32'h40000000, 4'b1000, 1'b1);
        chk("t3_len", 64'(tile_len_o), 64'd1);
        chk("t3_rdy_g3", 64'(in_ready_o), 64'd1);

        // Back-to-back: next tile starts in the done-pulse cycle
        beat(32'h05050505, 1'b0);
        tick();
        lanes("t4_h0", 32'h00000005, 4'b0001, 1'b0);
        chk("t4_len_hold", 64'(tile_len_o), 64'd1);
        beat(32'h06060606, 1'b1);
        tick();
        idle();
        lanes("t4_h1", 32'h00000506, 4'b0011, 1'b0);
        tick();
        tick();
        lanes("t4_h3", 32'h05060000, 4'b1100, 1'b0);
        tick();
        lanes("t4_h4", 32'h06000000, 4'b1000, 1'b1);
        chk("t4_len", 64'(tile_len_o), 64'd2);

        // Async reset mid-FLUSH
        tick();
        beat(32'h07070707, 1'b1);
        tick();
        idle();
        tick();
        #2;
        reset = 1'b1;
        #1;
        lanes("t5_rst", 32'h0, 4'h0, 1'b0);
        chk("t5_rst_rdy", 64'(in_ready_o), 64'd0);
        chk("t5_rst_busy", 64'(busy_o), 64'd0);
        chk("t5_rst_len", 64'(tile_len_o), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("t5_rel_rdy", 64'(in_ready_o), 64'd1);
        tick();
        lanes("t5_a", 32'h0, 4'h0, 1'b0);
        tick();
        lanes("t5_b", 32'h0, 4'h0, 1'b0);
        chk("t5_idle", 64'(busy_o), 64'd0);

        // SIZE=1 build
        v1 = 1'b1; d1 = 8'h5A; l1 = 1'b1;
        #1;
        chk("s1_rdy_pre", 64'(rdy1), 64'd1);
        tick();
        chk("s1_data", 64'(ld1), 64'h5A);
        chk("s1_vld", 64'(lv1), 64'd1);
        chk("s1_done", 64'(done1), 64'd1);
        chk("s1_len", 64'(len1), 64'd1);
        chk("s1_rdy", 64'(rdy1), 64'd1);
        d1 = 8'hA5;
        tick();
        chk("s1b_data", 64'(ld1), 64'hA5);
        chk("s1b_done", 64'(done1), 64'd1);
        chk("s1b_len", 64'(len1), 64'd1);
        v1 = 1'b0; l1 = 1'b0; d1 = '0;
        tick();
        chk("s1_end_done", 64'(done1), 64'd0);
        chk("s1_end_vld", 64'(lv1), 64'd0);
        chk("s1_end_busy", 64'(busy1), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_a_skew_feeder.md
Name: sa_a_skew_feeder

Overview:
- Upstream feeder for the west edge of the INT8 systolic array.
- Accepts one SIZE-element int8 A-row vector per beat on a ready/valid interface.
- Drives each array row's A_in input with diagonal skew: lane i is delayed i cycles beyond lane 0.
- Drains the skew pipeline with zeros at tile end and reports tile completion and tile length.

Parameters:
- SIZE, 4, number of array rows / lanes (>=1).
- CNT_W, 16, width of the tile beat counter and of tile_len_o.

Ports:
- clk_i  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid_i  input  1  upstream vector valid.
- in_ready_o  output  1  feeder can accept a vector.
- in_data_i  input  SIZE*8  vector; element i = in_data_i[8i+7:8i], int8_t.
- in_last_i  input  1  qualifies final vector of a tile.
- lane_data_o  output  SIZE*8  lane i drives A_in of array row i.
- lane_valid_o  output  SIZE  per-lane valid, aligned with lane_data_o.
- busy_o  output  1  state != IDLE.
- tile_done_o  output  1  one-cycle pulse at tile drain complete.
- tile_len_o  output  CNT_W  beats in the last completed tile; held until next done.

Behaviour:
- Reset (async assert, sync release): state=IDLE, all skew registers and valids 0, lane_data_o=0, tile_done_o=0, tile_len_o=0, beat counter=0. in_ready_o is forced 0 while reset is high.
- Accept: a beat is accepted when in_valid_i && in_ready_o at a rising edge.
- in_ready_o = (state != FLUSH) && !reset; it is combinational from state only, never from in_valid_i.
- Skew: lane i is a chain of i+1 registers. An element accepted at edge E0 appears on lane i after edge E_i, so lane 0 latency is 1 cycle and lane i latency is i+1 cycles.
- Bubble: in a cycle with no accepted beat, stage 0 of every lane loads 0 with valid 0. The pipeline advances every cycle and never stalls.
- Zeros are MAC-neutral (0*B = 0). B-side alignment is the system's responsibility.
- FSM states: IDLE, STREAM, FLUSH.
  - IDLE: accepted beat with !last -> STREAM. Accepted beat with last -> FLUSH, or straight to IDLE with a done pulse if SIZE==1.
  - STREAM: accepted beat with last -> FLUSH, or IDLE with a done pulse if SIZE==1. Otherwise stay in STREAM; bubbles are allowed.
  - FLUSH: lasts exactly SIZE-1 cycles, tracked by a flush counter. Zeros are injected throughout. At the edge ending the final FLUSH cycle -> IDLE.
- Done pulse: tile_done_o is registered high for exactly one cycle.
  - It is the cycle in which the last vector's element SIZE-1 is on lane SIZE-1, i.e. after edge E_{SIZE-1} relative to the last beat.
  - in_ready_o is already 1 in that cycle, so a beat may be accepted while the done pulse is high.
- Beat counter: increments on each accepted beat and saturates at 2^CNT_W-1. On the done edge, tile_len_o <= final count including the last beat, and the counter clears to 0.
- lane_valid_o[i] is high only for lane data originating from accepted beats.
- Reset mid-tile: immediate return to reset values. The partial tile is discarded, with no done pulse.
- in_last_i is ignored unless the beat is accepted.

Test Plan:
- SIZE=4, 3 back-to-back beats; vectors {1,2,3,4},{5,6,7,8},{9,10,11,-12}; last on beat 3 (accepted E0..E2).
  - lane0 outputs 1,5,9 after E0..E2; lane3 outputs 4,8,-12 after E3..E5.
  - in_ready_o is low for the 3 cycles after E2.
  - tile_done_o pulses after E5; tile_len_o=3.
- Bubble mid-tile: beat {1,1,1,1}, one idle cycle, then beat {2,2,2,2} with last.
  - Each lane shows 1,0,2 with valid 1,0,1, lane i shifted by i cycles.
  - tile_len_o=2.
- Single-beat tile from IDLE with last on the first beat -> FSM goes straight to FLUSH; done pulses 3 cycles after acceptance (SIZE=4); tile_len_o=1.
- Back-to-back tiles: new beat presented in the done-pulse cycle -> accepted, next tile streams, no lost or duplicated data, second tile_len_o correct.
- Async reset asserted mid-FLUSH, between clock edges -> outputs zero immediately, in_ready_o=0, no done pulse; after release, state is IDLE and in_ready_o=1.
- SIZE=1 build: beat with last -> lane0 shows data after 1 edge and tile_done_o pulses in that same cycle; in_ready_o never drops.
